// File: rtl/column_stream_tx_pkg.sv
// Shared types and default sizing for the column stream transmitter.
// Holds the FSM state encoding and the default column geometry.
package column_stream_tx_pkg;

  localparam int DEF_K           = 3;
  localparam int DEF_PIXEL_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_VALID = 3'd3,
    ST_DONE  = 3'd4
  } tx_state_e;

endpackage

// File: rtl/column_stream_tx_assembler.sv
// K-slot pixel capture register; slot i lands at bits [(i+1)*PIXEL_WIDTH-1 -: PIXEL_WIDTH]
// of the flat column word.
module column_assembler
  import column_stream_tx_pkg::*;
#(
  parameter int K           = DEF_K,
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int IDX_WIDTH   = (K > 1) ? $clog2(K) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [IDX_WIDTH-1:0]     wr_idx,
  input  logic [PIXEL_WIDTH-1:0]   din,
  output logic [K*PIXEL_WIDTH-1:0] dout
);

  logic [PIXEL_WIDTH-1:0] slots_r [K];

  // capture one pixel per write into its slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) begin
        slots_r[i] <= {PIXEL_WIDTH{1'b0}};
      end
    end else if (wr_en && (int'(wr_idx) < K)) begin
      slots_r[wr_idx] <= din;
    end else begin
      slots_r <= slots_r;
    end
  end

  for (genvar g = 0; g < K; g++) begin : g_flat
    assign dout[(g+1)*PIXEL_WIDTH-1 -: PIXEL_WIDTH] = slots_r[g];
  end

endmodule

// File: rtl/column_stream_tx.sv
// Reads a raster image from a 1-cycle BRAM port and streams every vertical K-pixel column.
// Optional COLUMN_TX_ZDRIVE_EN: out floats to all-z instead of all-zero while out_valid=0.
module column_stream_tx
  import column_stream_tx_pkg::*;
#(
  parameter int K           = DEF_K,
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int IMG_W       = 64,
  parameter int IMG_H       = 64,
  parameter int ADDR_WIDTH  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     rd_en,
  output logic [ADDR_WIDTH-1:0]    rd_addr,
  input  logic [PIXEL_WIDTH-1:0]   rd_data,
  output logic [K*PIXEL_WIDTH-1:0] out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     complete
);

  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam logic [KW-1:0]         K_LAST   = KW'(K - 1);
  localparam logic [XW-1:0]         X_LAST   = XW'(IMG_W - 1);
  localparam logic [YW-1:0]         Y_LAST   = YW'(IMG_H - K);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(IMG_W);

  tx_state_e               state_r, state_s;
  logic [KW-1:0]           k_r;
  logic [XW-1:0]           x_r;
  logic [YW-1:0]           y_r;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic [ADDR_WIDTH-1:0]   rd_addr_r;
  logic                    rd_en_r, out_valid_r, complete_r;
  logic                    cap_en_r;
  logic [KW-1:0]           cap_idx_r;
  logic                    last_col_s, handshake_s;
  logic [K*PIXEL_WIDTH-1:0] col_s;

  assign last_col_s  = (x_r == X_LAST) && (y_r == Y_LAST);
  assign handshake_s = (state_r == ST_VALID) && out_ready;

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_FETCH;
        else       state_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (k_r == K_LAST) state_s = ST_DRAIN;
        else               state_s = ST_FETCH;
      end
      ST_DRAIN: state_s = ST_VALID;
      ST_VALID: begin
        if (out_ready) begin
          if (last_col_s) state_s = ST_DONE;
          else            state_s = ST_FETCH;
        end else begin
          state_s = ST_VALID;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // state register and state-decoded registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      rd_en_r     <= 1'b0;
      out_valid_r <= 1'b0;
      complete_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      rd_en_r     <= (state_s == ST_FETCH);
      out_valid_r <= (state_s == ST_VALID);
      complete_r  <= (state_s == ST_DONE);
    end
  end

  // column position and read address; base = y*IMG_W + x so it simply increments per column
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_r       <= {KW{1'b0}};
      x_r       <= {XW{1'b0}};
      y_r       <= {YW{1'b0}};
      base_r    <= {ADDR_WIDTH{1'b0}};
      rd_addr_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      k_r <= ((state_r == ST_FETCH) && (state_s == ST_FETCH)) ? k_r + KW'(1) : {KW{1'b0}};
      if ((state_r == ST_IDLE) && start) begin
        x_r       <= {XW{1'b0}};
        y_r       <= {YW{1'b0}};
        base_r    <= {ADDR_WIDTH{1'b0}};
        rd_addr_r <= {ADDR_WIDTH{1'b0}};
      end else if (handshake_s && !last_col_s) begin
        base_r    <= base_r + ADDR_WIDTH'(1);
        rd_addr_r <= base_r + ADDR_WIDTH'(1);
        if (x_r == X_LAST) begin
          x_r <= {XW{1'b0}};
          y_r <= y_r + YW'(1);
        end else begin
          x_r <= x_r + XW'(1);
        end
      end else if (state_r == ST_FETCH) begin
        rd_addr_r <= rd_addr_r + ROW_STEP;
      end else begin
        rd_addr_r <= rd_addr_r;
      end
    end
  end

  // read data returns one cycle after rd_en, so the slot index trails by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_en_r  <= 1'b0;
      cap_idx_r <= {KW{1'b0}};
    end else begin
      cap_en_r  <= rd_en_r;
      cap_idx_r <= k_r;
    end
  end

  column_assembler #(
    .K           (K),
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .IDX_WIDTH   (KW)
  ) u_assembler (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (cap_en_r),
    .wr_idx (cap_idx_r),
    .din    (rd_data),
    .dout   (col_s)
  );

  assign rd_en     = rd_en_r;
  assign rd_addr   = rd_addr_r;
  assign out_valid = out_valid_r;
  assign complete  = complete_r;

`ifdef COLUMN_TX_ZDRIVE_EN
  assign out = out_valid_r ? col_s : {(K*PIXEL_WIDTH){1'bz}};
`else
  assign out = out_valid_r ? col_s : {(K*PIXEL_WIDTH){1'b0}};
`endif

endmodule

// File: tb/tb_column_stream_tx.sv
// Scoreboard bench for column_stream_tx on a 4x4 image with K=3, BRAM model mem[a]=a.
module tb_column_stream_tx;

  localparam int K    = 3;
  localparam int PW   = 8;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int AW   = 12;
  localparam int NCOL = (H - K + 1) * W;

  logic          clk = 1'b0;
  logic          rst_n, start, rd_en, out_valid, out_ready, complete;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data;
  logic [K*PW-1:0] out;
  logic [K*PW-1:0] idle_word;

  int n_checks = 0;
  int n_fail   = 0;
  logic [K*PW-1:0] sb[$];
  logic [AW-1:0]   wrap_addrs[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_data <= rd_addr[PW-1:0];
  end

  column_stream_tx #(
    .K(K), .PIXEL_WIDTH(PW), .IMG_W(W), .IMG_H(H), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .complete(complete)
  );

  function automatic logic [K*PW-1:0] col_word(input int idx);
    logic [K*PW-1:0] w;
    int x, y;
    x = idx % W;
    y = idx / W;
    for (int i = 0; i < K; i++) w[i*PW +: PW] = PW'((y + i) * W + x);
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    #12;
    n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    n_checks++; if (rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (complete !== 1'b0) begin n_fail++; $display("FAIL reset_complete: got %b want 0", complete); end
    n_checks++; if (out !== idle_word) begin n_fail++; $display("FAIL reset_out: got %h want %h", out, idle_word); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // Runs one frame from a start pulse; stall_col/stall_len hold out_ready low on one column,
  // busy_at pulses start in that cycle (cycle 0 is the one carrying the start pulse).
  task automatic run_frame(input string name, input int stall_col, input int stall_len,
                           input int busy_at, input bit timing);
    int hs = 0, fetch_k = 0, stall_left, first_valid = -1, complete_cyc = -1;
    int n_complete = 0, post = -1, cyc;
    int exp_addr;
    logic [K*PW-1:0] exp_col;
    stall_left = stall_len;
    wrap_addrs.delete();
    @(posedge clk); #1;
    start = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < NCOL; i++) sb.push_back(col_word(i));
    for (cyc = 1; cyc <= 300 && post < 3; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == busy_at);
      out_ready = 1'b1;
      if (post >= 0) begin
        post++;
        n_checks++;
        if (out_valid !== 1'b0 || rd_en !== 1'b0) begin
          n_fail++; $display("FAIL %s_quiet_after_done: out_valid=%b rd_en=%b want 0 0", name, out_valid, rd_en);
        end
      end
      if (rd_en === 1'b1) begin
        exp_addr = ((hs / W) + fetch_k) * W + (hs % W);
        n_checks++;
        if (rd_addr !== AW'(exp_addr)) begin
          n_fail++; $display("FAIL %s_rd_addr col %0d k %0d: got %0d want %0d", name, hs, fetch_k, rd_addr, exp_addr);
        end
        if (hs == 4) wrap_addrs.push_back(rd_addr);
        fetch_k++;
      end
      if (out_valid !== 1'b1) begin
        n_checks++;
        if (out !== idle_word) begin n_fail++; $display("FAIL %s_idle_out: got %h want %h", name, out, idle_word); end
      end
      if (complete === 1'b1) begin
        n_complete++;
        if (complete_cyc < 0) complete_cyc = cyc;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_complete_with_valid: out_valid=%b want 0", name, out_valid); end
        if (post < 0) post = 0;
      end
      if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (out_valid === 1'b1 && hs == stall_col && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        n_checks++;
        if (out !== sb[0] || rd_en !== 1'b0) begin
          n_fail++; $display("FAIL %s_stall: out=%h rd_en=%b want %h 0", name, out, rd_en, sb[0]);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL %s_extra_column: got %h want none", name, out);
        end else begin
          exp_col = sb.pop_front();
          if (out !== exp_col) begin n_fail++; $display("FAIL %s_column %0d: got %h want %h", name, hs, out, exp_col); end
        end
        hs++;
        fetch_k = 0;
      end
    end
    out_ready = 1'b1; start = 1'b0;
    n_checks++; if (post < 3) begin n_fail++; $display("FAIL %s_timeout: got no complete want complete within 300 cycles", name); end
    n_checks++; if (hs != NCOL) begin n_fail++; $display("FAIL %s_column_count: got %0d want %0d", name, hs, NCOL); end
    n_checks++; if (n_complete != 1) begin n_fail++; $display("FAIL %s_complete_pulses: got %0d want 1", name, n_complete); end
    if (timing) begin
      n_checks++;
      if (first_valid != K + 2) begin n_fail++; $display("FAIL %s_first_valid_cycle: got %0d want %0d", name, first_valid, K + 2); end
      n_checks++;
      if (complete_cyc != (K + 2) * NCOL + 1) begin
        n_fail++; $display("FAIL %s_complete_cycle: got %0d want %0d", name, complete_cyc, (K + 2) * NCOL + 1);
      end
    end
    sb.delete();
  endtask

  task automatic test_basic();
    run_frame("basic", -1, 0, -1, 1'b1);
  endtask

  task automatic test_backpressure();
    run_frame("backpressure", 2, 5, -1, 1'b0);
  endtask

  task automatic test_busy_start();
    run_frame("busy_mid", -1, 0, 12, 1'b1);
    run_frame("busy_done", -1, 0, (K + 2) * NCOL + 1, 1'b1);
  endtask

  task automatic test_band_wrap();
    run_frame("band_wrap", -1, 0, -1, 1'b0);
    n_checks++;
    if (wrap_addrs.size() != 3) begin
      n_fail++; $display("FAIL band_wrap_reads: got %0d want 3", wrap_addrs.size());
    end else if (wrap_addrs[0] !== AW'(4) || wrap_addrs[1] !== AW'(8) || wrap_addrs[2] !== AW'(12)) begin
      n_fail++; $display("FAIL band_wrap_addrs: got %0d,%0d,%0d want 4,8,12", wrap_addrs[0], wrap_addrs[1], wrap_addrs[2]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int seen = 0;
    bit hit = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (seen == 3 && rd_en === 1'b1) hit = 1'b1;
      else if (out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL midreset_reach_fetch: got no fetch of column 4 want one"); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL midreset_rd_en: got %b want 0", rd_en); end
    n_checks++; if (rd_addr !== '0) begin n_fail++; $display("FAIL midreset_rd_addr: got %0d want 0", rd_addr); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (complete !== 1'b0) begin n_fail++; $display("FAIL midreset_complete: got %b want 0", complete); end
    n_checks++; if (out !== idle_word) begin n_fail++; $display("FAIL midreset_out: got %h want %h", out, idle_word); end
    @(negedge clk); rst_n = 1'b1;
    run_frame("after_reset", -1, 0, -1, 1'b1);
  endtask

  initial begin
`ifdef COLUMN_TX_ZDRIVE_EN
    idle_word = {(K*PW){1'bz}};
`else
    idle_word = {(K*PW){1'b0}};
`endif
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_busy_start();
    test_band_wrap();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
